// File: rtl/softmax_norm_sched.sv
// Softmax normalisation scheduler: buffers one N-element vector, sums it, then
// drives an external iterative divider once per element to produce probabilities.
module softmax_norm_sched #(
  parameter int unsigned D_W  = 32,
  parameter int unsigned N    = 8,
  parameter int unsigned FRAC = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [D_W-1:0] in_data,
  output logic           in_ready,
  output logic           div_in_valid,
  output logic [D_W-1:0] div_divident,
  output logic [D_W-1:0] div_divisor,
  input  logic [D_W-1:0] div_quotient,
  input  logic           div_out_valid,
  output logic           out_valid,
  output logic [D_W-1:0] out_data,
  output logic           out_last
);

  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned SUM_W = D_W + $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_WAIT, S_ZERO} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] sum_next;
  logic [D_W-1:0]   elem_buf [N];
  logic [D_W-1:0]   sum_sat;

  // Sum carries $clog2(N) guard bits so accumulation cannot wrap.
  assign sum_next = sum + SUM_W'(in_data);
  assign sum_sat  = (sum[SUM_W-1:D_W] != '0) ? '1 : sum[D_W-1:0];

  // Element storage carries no reset; only the captured slots are ever read.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && in_valid) elem_buf[idx] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_LOAD;
      idx          <= '0;
      sum          <= '0;
      in_ready     <= 1'b1;
      div_in_valid <= 1'b0;
      div_divident <= '0;
      div_divisor  <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_data     <= '0;
    end else begin
      div_in_valid <= 1'b0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      unique case (state)
        S_LOAD: begin
          if (in_valid) begin
            sum <= sum_next;
            if (idx == LAST_IDX) begin
              idx      <= '0;
              in_ready <= 1'b0;
              state    <= (sum_next == '0) ? S_ZERO : S_ISSUE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        S_ISSUE: begin
          // Operands stay registered and untouched until the result returns.
          div_in_valid <= 1'b1;
          div_divident <= D_W'(elem_buf[idx] << FRAC);
          div_divisor  <= sum_sat;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          if (div_out_valid) begin
            out_valid <= 1'b1;
            out_data  <= div_quotient;
            out_last  <= (idx == LAST_IDX);
            if (idx == LAST_IDX) begin
              idx      <= '0;
              sum      <= '0;
              in_ready <= 1'b1;
              state    <= S_LOAD;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= S_ISSUE;
            end
          end
        end
        S_ZERO: begin
          // All-zero vector: skip the divider, which cannot divide by zero.
          out_valid <= 1'b1;
          out_data  <= '0;
          out_last  <= (idx == LAST_IDX);
          if (idx == LAST_IDX) begin
            idx      <= '0;
            sum      <= '0;
            in_ready <= 1'b1;
            state    <= S_LOAD;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_norm_sched.sv
// Bench for softmax_norm_sched: randomized vectors against an arithmetic softmax
// reference, with a behavioural variable-latency divider standing in for div.
module tb_softmax_norm_sched;

  localparam int unsigned D_W  = 32;
  localparam int unsigned N    = 4;
  localparam int unsigned FRAC = 8;
  localparam int unsigned BW   = 16;
  localparam int unsigned BN   = 2;
  localparam int unsigned BF   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           in_valid, in_ready, div_in_valid, div_out_valid, out_valid, out_last;
  logic [D_W-1:0] in_data, div_divident, div_divisor, div_quotient, out_data;
  logic           spur;

  logic          b_in_valid, b_in_ready, b_div_in_valid, b_div_out_valid, b_out_valid, b_out_last;
  logic [BW-1:0] b_in_data, b_div_divident, b_div_divisor, b_div_quotient, b_out_data;

  softmax_norm_sched #(.D_W(D_W), .N(N), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .div_in_valid(div_in_valid), .div_divident(div_divident), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_out_valid(div_out_valid),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last));

  softmax_norm_sched #(.D_W(BW), .N(BN), .FRAC(BF)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .div_in_valid(b_div_in_valid), .div_divident(b_div_divident), .div_divisor(b_div_divisor),
    .div_quotient(b_div_quotient), .div_out_valid(b_div_out_valid),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last));

  // Divider models: random 1..4 cycle latency, quotient taken from the operands
  // present when the result is produced (so unstable operands show up as errors).
  int unsigned    lat_a, lat_b;
  logic           busy_a, pulse_a, busy_b, pulse_b;
  logic [D_W-1:0] q_a;
  logic [BW-1:0]  q_b;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_a <= 1'b0; pulse_a <= 1'b0; lat_a <= 0; q_a <= '0;
    end else begin
      pulse_a <= 1'b0;
      if (div_in_valid) begin
        busy_a <= 1'b1; lat_a <= $urandom_range(4, 1);
      end else if (busy_a) begin
        if (lat_a <= 1) begin
          busy_a  <= 1'b0; pulse_a <= 1'b1;
          q_a     <= (div_divisor == '0) ? '1 : div_divident / div_divisor;
        end else lat_a <= lat_a - 1;
      end
    end
  end
  assign div_quotient  = q_a;
  assign div_out_valid = pulse_a | spur;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_b <= 1'b0; pulse_b <= 1'b0; lat_b <= 0; q_b <= '0;
    end else begin
      pulse_b <= 1'b0;
      if (b_div_in_valid) begin
        busy_b <= 1'b1; lat_b <= $urandom_range(4, 1);
      end else if (busy_b) begin
        if (lat_b <= 1) begin
          busy_b  <= 1'b0; pulse_b <= 1'b1;
          q_b     <= (b_div_divisor == '0) ? '1 : b_div_divident / b_div_divisor;
        end else lat_b <= lat_b - 1;
      end
    end
  end
  assign b_div_quotient  = q_b;
  assign b_div_out_valid = pulse_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int starts   = 0;
  logic [D_W-1:0] vec [N];
  logic [D_W-1:0] obs_data [$];
  logic           obs_last [$];
  int             obs_cyc  [$];
  logic [BW-1:0]  obs_b    [$];
  logic           obs_b_last [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && div_in_valid) starts <= starts + 1;
  end

  always @(negedge clk) begin
    if (out_valid) begin
      obs_data.push_back(out_data); obs_last.push_back(out_last); obs_cyc.push_back(cyc);
    end
    if (b_out_valid) begin
      obs_b.push_back(b_out_data); obs_b_last.push_back(b_out_last);
    end
  end

  // Softmax reference: p_i = ((x_i << FRAC) mod 2^D_W) / min(sum, 2^D_W-1), 0 if sum==0.
  function automatic logic [D_W-1:0] ref_q(input int i);
    longint unsigned s, dv, num, lim;
    lim = (64'd1 << D_W) - 64'd1;
    s = 0;
    for (int k = 0; k < N; k++) s += 64'(vec[k]);
    if (s == 0) return '0;
    dv  = (s > lim) ? lim : s;
    num = (64'(vec[i]) << FRAC) & lim;
    return D_W'(num / dv);
  endfunction

  function automatic logic [D_W-1:0] rand_elem();
    return D_W'($urandom_range(32'h00FF_FFFF, 0));
  endfunction

  task automatic drive_vec(input bit hold);
    int  k = 0;
    int  guard = 0;
    bit  acc;
    while (k < N && guard < 200) begin
      in_valid = 1'b1; in_data = vec[k];
      acc = in_ready;
      @(posedge clk); #1; guard++;
      if (acc) k++;
    end
    if (hold) begin
      guard = 0;
      while (!in_ready && guard < 300) begin
        in_valid = 1'b1; in_data = D_W'($urandom_range(32'h00FF_FFFF, 0));
        @(posedge clk); #1; guard++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_vec(input string tag);
    int guard = 0;
    while (obs_data.size() < N && guard < 300) begin @(negedge clk); guard++; end
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs_data.size() != N) begin
      n_fail++; $display("FAIL %s out_count: got %0d outputs, expected %0d", tag, obs_data.size(), N);
    end
    for (int i = 0; i < N && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== ref_q(i)) begin
        n_fail++; $display("FAIL %s out_data[%0d]: got %0d, expected %0d", tag, i, obs_data[i], ref_q(i));
      end
      n_checks++;
      if (obs_last[i] !== (i == N - 1)) begin
        n_fail++; $display("FAIL %s out_last[%0d]: got %0b, expected %0b", tag, i, obs_last[i], (i == N - 1));
      end
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s in_ready_after_last: got %0b, expected 1", tag, in_ready);
    end
  endtask

  task automatic clear_obs();
    obs_data.delete(); obs_last.delete(); obs_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, div_in_valid, out_valid, out_last} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_flags: got %4b, expected 1000", {in_ready, div_in_valid, out_valid, out_last});
    end
    n_checks++;
    if (out_data !== '0 || div_divident !== '0 || div_divisor !== '0) begin
      n_fail++; $display("FAIL reset_data: got out=%0h dvd=%0h dvs=%0h, expected 0", out_data, div_divident, div_divisor);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %0b, expected 1", in_ready);
    end
  endtask

  task automatic test_directed();
    int s0;
    vec = '{32'd1, 32'd1, 32'd1, 32'd1};
    drive_vec(1'b0); check_vec("uniform"); clear_obs();
    vec = '{32'd3, 32'd1, 32'd0, 32'd0};
    s0 = starts;
    drive_vec(1'b0); check_vec("skewed"); clear_obs();
    n_checks++;
    if (starts - s0 != N) begin
      n_fail++; $display("FAIL skewed_div_starts: got %0d, expected %0d", starts - s0, N);
    end
  endtask

  task automatic test_zero();
    int s0;
    vec = '{32'd0, 32'd0, 32'd0, 32'd0};
    s0 = starts;
    drive_vec(1'b0); check_vec("zero");
    n_checks++;
    if (starts != s0) begin
      n_fail++; $display("FAIL zero_div_starts: got %0d, expected 0", starts - s0);
    end
    for (int i = 1; i < obs_cyc.size(); i++) begin
      n_checks++;
      if (obs_cyc[i] != obs_cyc[0] + i) begin
        n_fail++; $display("FAIL zero_consecutive[%0d]: got cycle %0d, expected %0d", i, obs_cyc[i], obs_cyc[0] + i);
      end
    end
    clear_obs();
  endtask

  task automatic test_hold_valid();
    for (int k = 0; k < N; k++) vec[k] = rand_elem();
    drive_vec(1'b1); check_vec("hold"); clear_obs();
    drive_vec(1'b0); check_vec("hold_fresh"); clear_obs();
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < N; k++)
        vec[k] = ($urandom_range(3, 0) == 0) ? '0 : (t[0] ? D_W'($urandom_range(20, 0)) : rand_elem());
      drive_vec(1'b0); check_vec("random"); clear_obs();
    end
  endtask

  task automatic test_spurious();
    spur = 1'b1; @(posedge clk); #1; spur = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if (obs_data.size() != 0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL spurious_div_out: got %0d outputs ready=%0b, expected 0 outputs ready=1", obs_data.size(), in_ready);
    end
    clear_obs();
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    vec = '{32'd5, 32'd6, 32'd7, 32'd8};
    drive_vec(1'b0);
    while (obs_data.size() < 2 && guard < 200) begin @(negedge clk); guard++; end
    guard = 0;
    while (!div_in_valid && guard < 50) begin @(negedge clk); guard++; end
    n_checks++;
    if (!div_in_valid) begin
      n_fail++; $display("FAIL reset_mid_issue: got no third divider start, expected one");
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_ready: got %0b, expected 1", in_ready);
    end
    repeat (8) @(posedge clk); #1;
    n_checks++;
    if (obs_data.size() != 2) begin
      n_fail++; $display("FAIL reset_mid_quiet: got %0d outputs, expected 2", obs_data.size());
    end
    clear_obs();
    vec = '{32'd2, 32'd2, 32'd0, 32'd0};
    drive_vec(1'b0); check_vec("after_reset"); clear_obs();
  endtask

  task automatic test_narrow();
    int guard = 0;
    b_in_valid = 1'b1; b_in_data = 16'h0FFF;
    repeat (2) begin @(posedge clk); #1; end
    b_in_valid = 1'b0;
    while (!b_div_in_valid && guard < 50) begin @(negedge clk); guard++; end
    n_checks++;
    if (b_div_divisor !== 16'h1FFE || b_div_divident !== 16'hFFF0) begin
      n_fail++; $display("FAIL narrow_operands: got %h/%h, expected fff0/1ffe", b_div_divident, b_div_divisor);
    end
    guard = 0;
    while (obs_b.size() < BN && guard < 100) begin @(negedge clk); guard++; end
    n_checks++;
    if (obs_b.size() != BN) begin
      n_fail++; $display("FAIL narrow_count: got %0d outputs, expected %0d", obs_b.size(), BN);
    end
    for (int i = 0; i < obs_b.size(); i++) begin
      n_checks++;
      if (obs_b[i] !== 16'd8 || obs_b_last[i] !== (i == BN - 1)) begin
        n_fail++; $display("FAIL narrow_out[%0d]: got %0d last=%0b, expected 8 last=%0b", i, obs_b[i], obs_b_last[i], (i == BN - 1));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; spur = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0;
    test_reset();
    test_directed();
    test_zero();
    test_spurious();
    test_hold_valid();
    test_random();
    test_reset_mid();
    test_narrow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
